// File: rtl/prescaled_updown_counter.sv
// Up/down event counter advanced by a programmable prescaler, with
// wrap or saturate behaviour against an inclusive limit and synchronous load.
module prescaled_updown_counter #(
  parameter int WIDTH = 16,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PRE_W-1:0] div,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             tick,
  output logic             tc,
  output logic             sat
);

  logic [PRE_W-1:0] r_pre;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_tc;

  logic [PRE_W-1:0] w_pre_next;
  logic [WIDTH-1:0] w_count_next;
  logic             w_tick_next;
  logic             w_tc_next;

  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_step_val;
  logic             w_step_tc;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_step;

  assign w_inc          = r_count + WIDTH'(1);
  assign w_dec          = r_count - WIDTH'(1);
  assign w_load_clamped = (load_val > limit) ? limit : load_val;
  // A lowered div below the running prescaler still fires on the next enabled cycle.
  assign w_step         = (r_pre >= div);

  // Value and terminal-count flag that a step would produce this cycle.
  always_comb begin
    w_step_val = r_count;
    w_step_tc  = 1'b0;
    if (dir) begin
      if (r_count < limit) begin
        w_step_val = w_inc;
        w_step_tc  = mode && (w_inc == limit);
      end else if (!mode) begin
        w_step_val = '0;
        w_step_tc  = 1'b1;
      end else begin
        w_step_val = limit;
      end
    end else begin
      if (r_count != '0) begin
        w_step_val = w_dec;
        w_step_tc  = mode && (w_dec == '0);
      end else if (!mode) begin
        w_step_val = limit;
        w_step_tc  = 1'b1;
      end
    end
  end

  always_comb begin
    w_pre_next   = r_pre;
    w_count_next = r_count;
    w_tick_next  = 1'b0;
    w_tc_next    = 1'b0;
    if (load) begin
      w_count_next = w_load_clamped;
      w_pre_next   = '0;
    end else if (en) begin
      if (w_step) begin
        w_pre_next   = '0;
        w_count_next = w_step_val;
        w_tick_next  = 1'b1;
        w_tc_next    = w_step_tc;
      end else begin
        w_pre_next = r_pre + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      r_pre   <= w_pre_next;
      r_count <= w_count_next;
      r_tick  <= w_tick_next;
      r_tc    <= w_tc_next;
    end
  end

  assign counter = r_count;
  assign tick    = r_tick;
  assign tc      = r_tc;
  assign sat     = mode && (dir ? (r_count == limit) : (r_count == '0));

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench for prescaled_updown_counter: a table of per-cycle vectors
// followed by a few hand-written multi-cycle sequences.
module tb_prescaled_updown_counter;

  localparam int WIDTH = 16;
  localparam int PRE_W = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic [PRE_W-1:0] div;
  logic             dir;
  logic             mode;
  logic [WIDTH-1:0] limit;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] counter;
  logic             tick;
  logic             tc;
  logic             sat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic             rst_n;
    logic             ld;
    logic [WIDTH-1:0] lv;
    logic             en;
    logic [PRE_W-1:0] div;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] e_cnt;
    logic             e_tick;
    logic             e_tc;
    logic             e_sat;
  } vec_t;

  vec_t vecs[$];

  prescaled_updown_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk(clk), .reset(reset), .en(en), .div(div), .dir(dir), .mode(mode),
    .limit(limit), .load(load), .load_val(load_val),
    .counter(counter), .tick(tick), .tc(tc), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic row(input logic r, input logic ld, input int lv, input logic e,
                     input int dv, input logic d, input logic m, input int lim,
                     input int ec, input logic et, input logic etc_, input logic es);
    vec_t v;
    v.rst_n = r; v.ld = ld; v.lv = WIDTH'(lv); v.en = e; v.div = PRE_W'(dv);
    v.dir = d; v.mode = m; v.lim = WIDTH'(lim);
    v.e_cnt = WIDTH'(ec); v.e_tick = et; v.e_tc = etc_; v.e_sat = es;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic ld, input int lv, input logic e,
                       input int dv, input logic d, input logic m, input int lim);
    reset = r; load = ld; load_val = WIDTH'(lv); en = e; div = PRE_W'(dv);
    dir = d; mode = m; limit = WIDTH'(lim);
  endtask

  initial begin
    int cycles;
    drive(0, 0, 0, 1, 0, 1, 0, 'hFFFF);

    // Reset then release
    for (int i = 0; i < 3; i++) row(0, 0, 0, 1, 0, 1, 0, 'hFFFF, 0, 0, 0, 0);
    row(1, 0, 0, 1, 0, 1, 0, 'hFFFF, 1, 1, 0, 0);
    // Prescale by 4
    row(1, 1, 0, 0, 3, 1, 0, 'hFFFF, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) row(1, 0, 0, 1, 3, 1, 0, 'hFFFF, k / 4, (k % 4) == 0, 0, 0);
    // Wrap up at limit 9
    row(1, 1, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) row(1, 0, 0, 1, 0, 1, 0, 9, k % 10, 1, k == 10, 0);
    // Saturate down from 2
    row(1, 1, 2, 0, 0, 0, 1, 9, 2, 0, 0, 0);
    for (int k = 1; k <= 4; k++) row(1, 0, 0, 1, 0, 0, 1, 9, (k == 1) ? 1 : 0, 1, k == 2, k >= 2);
    // Saturate up at limit 3
    row(1, 1, 2, 0, 0, 1, 1, 3, 2, 0, 0, 0);
    row(1, 0, 0, 1, 0, 1, 1, 3, 3, 1, 1, 1);
    row(1, 0, 0, 1, 0, 1, 1, 3, 3, 1, 0, 1);
    // limit = 0 in wrap mode, both directions
    row(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0);
    row(1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0);
    row(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    // Value above a lowered limit decrements normally
    row(1, 1, 8, 0, 0, 0, 0, 9, 8, 0, 0, 0);
    row(1, 0, 0, 1, 0, 0, 0, 5, 7, 1, 0, 0);
    // Load clamp with the prescaler at 2; restart means 4 more cycles to the step
    row(1, 1, 0, 0, 3, 1, 0, 9, 0, 0, 0, 0);
    row(1, 0, 0, 1, 3, 1, 0, 9, 0, 0, 0, 0);
    row(1, 0, 0, 1, 3, 1, 0, 9, 0, 0, 0, 0);
    row(1, 1, 20, 1, 3, 1, 0, 9, 9, 0, 0, 0);
    for (int k = 0; k < 3; k++) row(1, 0, 0, 1, 3, 1, 0, 9, 9, 0, 0, 0);
    row(1, 0, 0, 1, 3, 1, 0, 9, 0, 1, 1, 0);
    // Enable gap with div=1, then reset while tick is high
    row(1, 1, 0, 0, 1, 1, 0, 'hFFFF, 0, 0, 0, 0);
    row(1, 0, 0, 1, 1, 1, 0, 'hFFFF, 0, 0, 0, 0);
    row(1, 0, 0, 0, 1, 1, 0, 'hFFFF, 0, 0, 0, 0);
    row(1, 0, 0, 0, 1, 1, 0, 'hFFFF, 0, 0, 0, 0);
    row(1, 0, 0, 1, 1, 1, 0, 'hFFFF, 1, 1, 0, 0);
    row(1, 0, 0, 1, 1, 1, 0, 'hFFFF, 1, 0, 0, 0);
    row(1, 0, 0, 1, 1, 1, 0, 'hFFFF, 2, 1, 0, 0);
    row(0, 0, 0, 1, 1, 1, 0, 'hFFFF, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].ld, int'(vecs[i].lv), vecs[i].en, int'(vecs[i].div),
            vecs[i].dir, vecs[i].mode, int'(vecs[i].lim));
      cyc();
      chk("counter", i, 32'(counter), 32'(vecs[i].e_cnt));
      chk("tick", i, 32'(tick), 32'(vecs[i].e_tick));
      chk("tc", i, 32'(tc), 32'(vecs[i].e_tc));
      chk("sat", i, 32'(sat), 32'(vecs[i].e_sat));
    end

    // Lowering div below the running prescaler steps on the next enabled cycle
    drive(1, 1, 0, 0, 3, 1, 0, 'hFFFF); cyc();
    drive(1, 0, 0, 1, 3, 1, 0, 'hFFFF); cyc(); cyc();
    chk("div_low_pre", 0, 32'(counter), 32'd0);
    div = 4'd1; cyc();
    chk("div_low_cnt", 0, 32'(counter), 32'd1);
    chk("div_low_tick", 0, 32'(tick), 32'd1);

    // After a load, first tick arrives exactly div+1 enabled cycles later
    drive(1, 1, 5, 0, 2, 1, 0, 'hFFFF); cyc();
    drive(1, 0, 0, 1, 2, 1, 0, 'hFFFF);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (!tick && cycles < 10);
    chk("tick_latency", 0, 32'(cycles), 32'd3);
    chk("tick_latency_cnt", 0, 32'(counter), 32'd6);

    // Reset beats load; sat follows mode=1, dir=0 at count 0
    drive(0, 1, 7, 1, 0, 0, 1, 9); cyc();
    chk("rst_over_load", 0, 32'(counter), 32'd0);
    chk("rst_sat", 0, 32'(sat), 32'd1);
    chk("rst_tick", 0, 32'(tick), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prescaled_updown_counter.md
Name: prescaled_updown_counter

Overview:
- Parametrised up/down event counter driven by a programmable prescaler.
- Counts in steps of one every (div+1) enabled clock cycles, up to a programmable limit, in either wrap or saturate mode.
- Provides synchronous load, a per-step tick and a terminal-count pulse.
- Used as the general timebase/event counter in lab designs, e.g. feeding hex display drivers and timers.

Parameters:
- WIDTH, 16, counter width in bits.
- PRE_W, 4, prescaler divider width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  count enable; prescaler and counter hold when low.
- div  input  PRE_W  prescale value; one step every div+1 enabled cycles.
- dir  input  1  1 = count up, 0 = count down.
- mode  input  1  0 = wrap, 1 = saturate.
- limit  input  WIDTH  top count value (inclusive).
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- counter  output  WIDTH  current count (registered).
- tick  output  1  one-cycle pulse, registered, high in the cycle the counter shows a new stepped value.
- tc  output  1  one-cycle pulse, registered, high when a step wraps or reaches a saturation bound.
- sat  output  1  level: mode=1 and counter at the bound for the current dir (limit if up, 0 if down).

Behaviour:
- Reset (reset=0 at rising edge) clears everything: counter=0, prescaler=0, tick=0, tc=0. sat is then 0 unless mode=1 and dir=0.
- Reset clears both prescaler and counter.
- Priority: reset > load > en.
- Load (load=1): counter <= min(load_val, limit); prescaler <= 0; tick=0; tc=0.
- en=0: counter and prescaler hold; tick=0; tc=0.
- en=1, prescaler < div: prescaler increments; no step; tick=0; tc=0.
- en=1, prescaler >= div: prescaler <= 0 and a step occurs; tick=1 in the following cycle, aligned with the new counter value.
  - div=0 gives a step every enabled cycle.
  - div lowered below the current prescaler value gives a step on the next enabled cycle.
- Step up (dir=1):
  - counter < limit: counter+1. tc=1 only if mode=1 and the new value equals limit.
  - counter >= limit, mode=0: counter <= 0, tc=1.
  - counter >= limit, mode=1: counter <= limit, tc=0 (already saturated).
- Step down (dir=0):
  - counter > 0: counter-1. Values above limit decrement normally. tc=1 only if mode=1 and the new value is 0.
  - counter == 0, mode=0: counter <= limit, tc=1.
  - counter == 0, mode=1: hold 0, tc=0.
- limit=0: wrap mode holds 0 and pulses tc on every step.
- Arithmetic is modulo 2^WIDTH. The comparison against limit prevents overflow past limit.
- Latency: one clock from the qualifying edge to the outputs. tick and tc are never high for more than one consecutive cycle unless steps occur every cycle (div=0).
- Changes to dir, mode or limit take effect at the next step. A mid-operation change is not an error.
- Reset asserted mid-count takes effect at the next edge regardless of en or load.

Test Plan:
- Reset: reset=0 for 3 cycles with en=1, div=0, dir=1 -> counter=0, tick=0, tc=0; release -> counter=1 one cycle after the first enabled edge.
- Prescale: limit=16'hFFFF, div=3, dir=1, mode=0, en=1 for 20 cycles from 0 -> counter=5; tick pulses exactly every 4th cycle; tc never asserted.
- Wrap up: limit=9, div=0, dir=1, mode=0, 12 enabled cycles from 0 -> sequence 1..9,0,1,2; single tc pulse with counter=0.
- Saturate down: load load_val=2, then dir=0, mode=1, div=0, 4 enabled cycles -> 1,0,0,0; tc pulse only with the first 0; sat=1 from then on; tick on every step.
- Load clamp and priority: limit=9, load_val=20, load=1 with en=1 and the prescaler at 2 -> counter=9, prescaler restarts (next step exactly div+1 enabled cycles later), tick=0.
- Enable gap and mid-run reset: div=1, toggle en 1,0,0,1,1 -> prescaler frozen during en=0 (step count 1, not 2); reset=0 asserted while tick=1 -> next cycle counter=0, tick=0.
